// File: rtl/argon_pkg.sv
// argon_pkg: shared widths and state encoding for the ALU sequencer
package argon_pkg;
  localparam int BUS_W = 16;
  localparam int OP_W = 4;
  typedef enum logic [2:0] {IDLE, LD_A, LD_B, LD_OP, LD_F, RD_Y, RD_F, RSP} state_t;
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request/response handshakes, ALU bus and ALU control strobes
interface alu_sequencer_if;
  import argon_pkg::*;
  logic i_req_valid;
  logic o_req_ready;
  logic [BUS_W-1:0] i_req_a;
  logic [BUS_W-1:0] i_req_b;
  logic [OP_W-1:0] i_req_op;
  logic i_req_load_f;
  logic [BUS_W-1:0] i_req_f;
  logic o_rsp_valid;
  logic i_rsp_ready;
  logic [BUS_W-1:0] o_rsp_y;
  logic [BUS_W-1:0] o_rsp_f;
  logic o_rsp_err;
  logic [BUS_W-1:0] o_bus;
  logic [BUS_W-1:0] i_bus;
  logic i_bus_valid;
  logic o_latchA;
  logic o_latchB;
  logic o_latchF;
  logic o_latchOp;
  logic o_outputY;
  logic o_outputF;
  modport slave (
    input i_req_valid, i_req_a, i_req_b, i_req_op, i_req_load_f, i_req_f, i_rsp_ready, i_bus, i_bus_valid,
    output o_req_ready, o_rsp_valid, o_rsp_y, o_rsp_f, o_rsp_err, o_bus,
    output o_latchA, o_latchB, o_latchF, o_latchOp, o_outputY, o_outputF
  );
  modport master (
    output i_req_valid, i_req_a, i_req_b, i_req_op, i_req_load_f, i_req_f, i_rsp_ready, i_bus, i_bus_valid,
    input o_req_ready, o_rsp_valid, o_rsp_y, o_rsp_f, o_rsp_err, o_bus,
    input o_latchA, o_latchB, o_latchF, o_latchOp, o_outputY, o_outputF
  );
endinterface

// File: rtl/alu_seq_timer.sv
// alu_seq_timer: wait-cycle counter that flags the last allowed cycle of a read state
module alu_seq_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt_q;
  assign o_expired = cnt_q == W'(TIMEOUT - 1);
  // count cycles spent waiting, saturating once the limit is reached
  always_ff @(posedge i_Clk)
    if (i_Reset || i_clear) cnt_q <= '0;
    else if (i_enable && !o_expired) cnt_q <= cnt_q + W'(1);
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: drives an external ALU through load/read phases for one request at a time
module alu_sequencer
  import argon_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input logic i_Clk,
  input logic i_Reset,
  alu_sequencer_if.slave sif
);
  state_t state_q;
  logic req_ready_q, rsp_valid_q, err_q, ldf_q;
  logic la_q, lb_q, lop_q, lf_q, oy_q, of_q;
  logic [BUS_W-1:0] b_q, f_q, bus_q, y_q, rf_q;
  logic [OP_W-1:0] op_q;
  logic rd, clr, expired;
  assign rd = state_q == RD_Y || state_q == RD_F;
  assign clr = !rd || (state_q == RD_Y && sif.i_bus_valid);
  alu_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_Clk(i_Clk),
    .i_Reset(i_Reset),
    .i_clear(clr),
    .i_enable(rd),
    .o_expired(expired)
  );
  assign sif.o_req_ready = req_ready_q;
  assign sif.o_rsp_valid = rsp_valid_q;
  assign sif.o_rsp_y = y_q;
  assign sif.o_rsp_f = rf_q;
  assign sif.o_rsp_err = err_q;
  assign sif.o_bus = bus_q;
  assign sif.o_latchA = la_q;
  assign sif.o_latchB = lb_q;
  assign sif.o_latchOp = lop_q;
  assign sif.o_latchF = lf_q;
  assign sif.o_outputY = oy_q;
  assign sif.o_outputF = of_q;
  // sequencer FSM; bus and strobes are registered for the state being entered
  always_ff @(posedge i_Clk)
    if (i_Reset) begin
      state_q <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      err_q <= 1'b0;
      ldf_q <= 1'b0;
      {la_q, lb_q, lop_q, lf_q, oy_q, of_q} <= '0;
      {b_q, f_q, bus_q, y_q, rf_q} <= '0;
      op_q <= '0;
    end else begin
      bus_q <= '0;
      {la_q, lb_q, lop_q, lf_q, oy_q, of_q} <= '0;
      case (state_q)
        IDLE: if (sif.i_req_valid) begin
          b_q <= sif.i_req_b;
          op_q <= sif.i_req_op;
          ldf_q <= sif.i_req_load_f;
          f_q <= sif.i_req_f;
          err_q <= 1'b0;
          req_ready_q <= 1'b0;
          bus_q <= sif.i_req_a;
          la_q <= 1'b1;
          state_q <= LD_A;
        end
        LD_A: begin
          bus_q <= b_q;
          lb_q <= 1'b1;
          state_q <= LD_B;
        end
        LD_B: begin
          bus_q <= {{(BUS_W-OP_W){1'b0}}, op_q};
          lop_q <= 1'b1;
          state_q <= LD_OP;
        end
        LD_OP: if (ldf_q) begin
          bus_q <= f_q;
          lf_q <= 1'b1;
          state_q <= LD_F;
        end else begin
          oy_q <= 1'b1;
          state_q <= RD_Y;
        end
        LD_F: begin
          oy_q <= 1'b1;
          state_q <= RD_Y;
        end
        RD_Y: if (sif.i_bus_valid) begin
          y_q <= sif.i_bus;
          of_q <= 1'b1;
          state_q <= RD_F;
        end else if (expired) begin
          err_q <= 1'b1;
          y_q <= '0;
          rf_q <= '0;
          rsp_valid_q <= 1'b1;
          state_q <= RSP;
        end else oy_q <= 1'b1;
        RD_F: if (sif.i_bus_valid) begin
          rf_q <= sif.i_bus;
          rsp_valid_q <= 1'b1;
          state_q <= RSP;
        end else if (expired) begin
          err_q <= 1'b1;
          y_q <= '0;
          rf_q <= '0;
          rsp_valid_q <= 1'b1;
          state_q <= RSP;
        end else of_q <= 1'b1;
        RSP: if (sif.i_rsp_ready) begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vector table plus reset/stall/glitch sequences
module tb_alu_sequencer;
  logic i_Clk = 1'b0;
  logic i_Reset;
  int total = 0;
  int pass = 0;
  int m_model = 0;
  logic m_glitch = 1'b0;
  logic [15:0] m_y = '0, m_f = '0;
  alu_sequencer_if sif ();
  alu_sequencer #(.TIMEOUT(8)) dut (.i_Clk(i_Clk), .i_Reset(i_Reset), .sif(sif));
  always #5 i_Clk = ~i_Clk;
  // model ALU: answers in the same cycle it sees a read strobe; optional stray valid in LD_A/LD_OP
  always_comb begin
    sif.i_bus_valid = ((m_model != 0) && sif.o_outputY) || ((m_model == 1) && sif.o_outputF) ||
                      (m_glitch && (sif.o_latchA || sif.o_latchOp));
    sif.i_bus = sif.o_outputY ? m_y : sif.o_outputF ? m_f : 16'hBAD0;
  end
  typedef struct {
    logic [15:0] a, b;
    logic [3:0] op;
    logic ldf;
    logic [15:0] f, my, mf;
    int model;
    logic glitch;
    int stall;
    logic [15:0] ey, ef;
    logic eerr;
    int lat, ycyc;
  } vec_t;
  vec_t tv[6];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic logic [5:0] strobes();
    return {sif.o_latchA, sif.o_latchB, sif.o_latchOp, sif.o_latchF, sif.o_outputY, sif.o_outputF};
  endfunction
  task automatic run(input vec_t v);
    int j, ycyc, bad_bus, bad_hot, bad_st, id, last, ord, eord;
    logic done;
    logic [15:0] eb;
    m_model = v.model;
    m_glitch = v.glitch;
    m_y = v.my;
    m_f = v.mf;
    sif.i_req_a = v.a;
    sif.i_req_b = v.b;
    sif.i_req_op = v.op;
    sif.i_req_load_f = v.ldf;
    sif.i_req_f = v.f;
    sif.i_req_valid = 1'b1;
    @(posedge i_Clk);
    j = 0; ycyc = 0; bad_bus = 0; bad_hot = 0; bad_st = 0; last = 0; ord = 0; done = 1'b0;
    while (!done && j < 40) begin
      @(negedge i_Clk);
      if (j == 0) begin
        sif.i_req_valid = 1'b0;
        chk("err_clear_on_accept", sif.o_rsp_err, 0);
      end
      if ($countones(strobes()) > 1) bad_hot++;
      id = sif.o_latchA ? 1 : sif.o_latchB ? 2 : sif.o_latchOp ? 3 : sif.o_latchF ? 4 :
           sif.o_outputY ? 5 : sif.o_outputF ? 6 : 0;
      if (id != 0 && id != last) begin
        ord = ord * 10 + id;
        last = id;
      end
      if (sif.o_outputY) ycyc++;
      eb = sif.o_latchA ? v.a : sif.o_latchB ? v.b : sif.o_latchOp ? {12'h000, v.op} :
           sif.o_latchF ? v.f : 16'h0000;
      if (sif.o_bus !== eb) bad_bus++;
      if (sif.o_rsp_valid) done = 1'b1;
      else begin
        @(posedge i_Clk);
        j++;
      end
    end
    eord = v.ldf ? 12345 : 1235;
    if (v.model != 0) eord = eord * 10 + 6;
    chk("latency", done ? j : -1, v.lat);
    chk("strobe_order", ord, eord);
    chk("one_hot_strobes", bad_hot, 0);
    chk("bus_values", bad_bus, 0);
    chk("outputY_cycles", ycyc, v.ycyc);
    chk("rsp_y", sif.o_rsp_y, v.ey);
    chk("rsp_f", sif.o_rsp_f, v.ef);
    chk("rsp_err", sif.o_rsp_err, v.eerr);
    if (v.stall > 0) begin
      sif.i_req_valid = 1'b1;
      for (int s = 0; s < v.stall; s++) begin
        if (!sif.o_rsp_valid || sif.o_req_ready || sif.o_rsp_y !== v.ey || sif.o_rsp_f !== v.ef ||
            sif.o_rsp_err !== v.eerr || strobes() != 0) bad_st++;
        @(posedge i_Clk);
        @(negedge i_Clk);
      end
      sif.i_req_valid = 1'b0;
      chk("stall_hold", bad_st, 0);
    end
    sif.i_rsp_ready = 1'b1;
    @(posedge i_Clk);
    @(negedge i_Clk);
    sif.i_rsp_ready = 1'b0;
    chk("after_handshake", {sif.o_req_ready, sif.o_rsp_valid, sif.o_rsp_err, sif.o_rsp_y, sif.o_rsp_f},
        {1'b1, 1'b0, v.eerr, v.ey, v.ef});
  endtask
  initial begin
    int bad;
    tv[0] = '{16'h0003, 16'h0004, 4'h1, 1'b0, 16'h0000, 16'h0007, 16'h0000, 1, 1'b0, 0, 16'h0007, 16'h0000, 1'b0, 5, 1};
    tv[1] = '{16'h0003, 16'h0004, 4'h1, 1'b1, 16'h0001, 16'h0007, 16'h0001, 1, 1'b0, 0, 16'h0007, 16'h0001, 1'b0, 6, 1};
    tv[2] = '{16'h1234, 16'h5678, 4'h2, 1'b0, 16'h0000, 16'h1111, 16'h2222, 0, 1'b0, 0, 16'h0000, 16'h0000, 1'b1, 11, 8};
    tv[3] = '{16'h00AA, 16'h0055, 4'hF, 1'b1, 16'h8000, 16'h00FF, 16'h8000, 2, 1'b0, 0, 16'h0000, 16'h0000, 1'b1, 13, 1};
    tv[4] = '{16'h0000, 16'h0000, 4'h0, 1'b1, 16'hFFFF, 16'h4444, 16'h5555, 0, 1'b0, 0, 16'h0000, 16'h0000, 1'b1, 12, 8};
    tv[5] = '{16'hFFFF, 16'h0001, 4'h3, 1'b0, 16'h0000, 16'h1357, 16'h0005, 1, 1'b1, 10, 16'h1357, 16'h0005, 1'b0, 5, 1};
    i_Reset = 1'b1;
    sif.i_req_valid = 1'b0;
    sif.i_req_a = '0;
    sif.i_req_b = '0;
    sif.i_req_op = '0;
    sif.i_req_load_f = 1'b0;
    sif.i_req_f = '0;
    sif.i_rsp_ready = 1'b0;
    repeat (3) @(posedge i_Clk);
    @(negedge i_Clk);
    i_Reset = 1'b0;
    @(posedge i_Clk);
    @(negedge i_Clk);
    chk("reset_req_ready", sif.o_req_ready, 1);
    chk("reset_rsp_valid", sif.o_rsp_valid, 0);
    chk("reset_bus", sif.o_bus, 0);
    chk("reset_strobes", strobes(), 0);
    chk("reset_rsp", {sif.o_rsp_err, sif.o_rsp_y, sif.o_rsp_f}, 0);
    for (int i = 0; i < 6; i++) run(tv[i]);
    m_model = 1;
    m_glitch = 1'b0;
    sif.i_req_a = 16'h0011;
    sif.i_req_b = 16'h0022;
    sif.i_req_op = 4'h4;
    sif.i_req_load_f = 1'b0;
    sif.i_req_valid = 1'b1;
    @(posedge i_Clk);
    @(negedge i_Clk);
    sif.i_req_valid = 1'b0;
    @(posedge i_Clk);
    @(negedge i_Clk);
    chk("mid_reset_in_ld_b", {sif.o_latchB, sif.o_bus}, {1'b1, 16'h0022});
    i_Reset = 1'b1;
    @(posedge i_Clk);
    @(negedge i_Clk);
    i_Reset = 1'b0;
    chk("mid_reset_strobes", strobes(), 0);
    chk("mid_reset_bus", sif.o_bus, 0);
    chk("mid_reset_rsp", {sif.o_rsp_valid, sif.o_rsp_err, sif.o_rsp_y, sif.o_rsp_f}, 0);
    chk("mid_reset_ready", sif.o_req_ready, 1);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge i_Clk);
      @(negedge i_Clk);
      if (sif.o_rsp_valid || strobes() != 0 || !sif.o_req_ready) bad++;
    end
    chk("dropped_request_silent", bad, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8: maximum cycles to wait for i_bus_valid in any read state.
REQ-002 SHALL have i_Clk  input  1: sole clock, rising edge.
REQ-003 SHALL have i_Reset  input  1: synchronous, active-high reset.
REQ-004 SHALL have i_req_valid  input  1; o_req_ready  output  1: request handshake.
REQ-005 SHALL have i_req_a, i_req_b  input  16 each: operands; i_req_op  input  4: ALU opcode.
REQ-006 SHALL have i_req_load_f  input  1; i_req_f  input  16: optional flags preload.
REQ-007 SHALL have o_rsp_valid  output  1; i_rsp_ready  input  1: response handshake.
REQ-008 SHALL have o_rsp_y, o_rsp_f  output  16 each: captured result and flags; o_rsp_err  output  1: timeout flag.
REQ-009 SHALL have o_bus  output  16: data to ALU i_bus; i_bus  input  16, i_bus_valid  input  1: data from ALU o_bus/o_bus_valid.
REQ-010 SHALL have o_latchA, o_latchB, o_latchF, o_latchOp, o_outputY, o_outputF  output  1 each: ALU control strobes.

Function
REQ-011 SHALL implement states IDLE, LD_A, LD_B, LD_OP, LD_F, RD_Y, RD_F, RSP.
REQ-012 SHALL assert o_req_ready only in IDLE; accept on i_req_valid && o_req_ready, registering all request fields.
REQ-013 SHALL, after accept, spend exactly one cycle each in LD_A (o_bus=A, o_latchA), LD_B (o_bus=B, o_latchB), LD_OP (o_bus={12'h000,op}, o_latchOp).
REQ-014 SHALL enter LD_F (o_bus=f, o_latchF, one cycle) after LD_OP only if load_f was 1, else go directly to RD_Y.
REQ-015 SHALL hold o_outputY in RD_Y until i_bus_valid sampled high, then capture i_bus into o_rsp_y and go to RD_F.
REQ-016 SHALL hold o_outputF in RD_F until i_bus_valid sampled high, then capture i_bus into o_rsp_f and go to RSP.
REQ-017 SHALL drive o_bus=16'h0000 in all states other than LD_*; at most one strobe high per cycle; all strobes low in IDLE and RSP.
REQ-018 SHALL clear the wait counter on entry to RD_Y and RD_F; if TIMEOUT cycles elapse without i_bus_valid, set o_rsp_err, load 16'h0000 into both o_rsp_y and o_rsp_f, go directly to RSP.
REQ-019 SHALL ignore i_bus_valid outside RD_Y/RD_F.
REQ-020 SHALL hold o_rsp_valid and stable o_rsp_* in RSP until i_rsp_ready; return to IDLE on the handshake cycle.
REQ-021 SHALL give minimum latency of 5 cycles from accept edge to o_rsp_valid (6 with load_f) when i_bus_valid responds immediately.
REQ-022 SHALL keep o_rsp_y/o_rsp_f/o_rsp_err stable after leaving RSP; clear o_rsp_err on next accept.

Reset
REQ-023 SHALL on i_Reset (any state, mid-sequence included) go to IDLE at the next edge with all strobes 0, o_bus=0, o_rsp_valid=0, o_rsp_y=o_rsp_f=0, o_rsp_err=0, counter 0; in-flight request dropped, no response.
REQ-024 SHALL drive o_req_ready=1 on the first cycle after reset deasserts.

Structure
REQ-025 SHALL take bus width (16), opcode width (4) and state encoding from shared package argon_pkg.
REQ-026 SHALL place the wait counter/timeout compare in one sub-module, alu_seq_timer (clear, enable, expired).

Verification
REQ-027 A=16'h0003, B=16'h0004, op=4'h1, no load_f, model ALU valid after 1 cycle, Y=16'h0007, F=16'h0000 -> strobe order latchA,latchB,latchOp,outputY,outputF; o_bus 0003,0004,0001; rsp_y=0007, err=0, latency 5.
REQ-028 load_f=1, f=16'h0001 -> LD_F one cycle, o_bus=0001 with o_latchF, latency 6.
REQ-029 Model never asserts i_bus_valid, TIMEOUT=8 -> RSP after 8 RD_Y cycles, err=1, rsp_y=rsp_f=0000, o_outputF never asserted.
REQ-030 i_rsp_ready held low 10 cycles -> o_rsp_valid and data stable, o_req_ready low throughout; new request accepted only after handshake.
REQ-031 i_Reset pulsed during LD_B -> next cycle IDLE, all strobes 0, o_rsp_valid never asserted for dropped request.
REQ-032 i_bus_valid pulsed in LD_A and LD_OP -> ignored; response values from RD_Y/RD_F only.
